instruction_sequencer: RTL and testbench
========================================

Name: instruction_sequencer

Overview:
- Generates the 6-bit state code that the processor's control unit consumes.
- Steps fetch1–fetch3, waits while IR settles, decodes the opcode from IR, and walks the matching execute-state chain before returning to fetch1.
- Sits between IR and the control unit. It is the producer end of the state interface; the control unit registers a control word from each state code.

Parameters:
- STATE_W, 6, width of state output.
- OPCODE_W, 8, width of opcode input from IR.
- DECODE_WAIT, 2, idle cycles between fetch3 and opcode sample; must be ≥1. Covers the control-unit register stage plus the IR load.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin execution from idle (level, sampled each edge).
- opcode  input  OPCODE_W  IR contents.
- state  output  STATE_W  state code to control unit.
- busy  output  1  sequencer running an instruction stream.
- halted  output  1  END executed; sticky until reset.
- illegal  output  1  unknown opcode seen; sticky until reset.
- instr_count  output  CNT_W  retired legal instructions, END excluded.

Behaviour:
- Reset (async, reset_n=0): state=0 (idle), busy=0, halted=0, illegal=0, instr_count=0, internal wait counter=0.
  - Takes effect immediately, including mid-instruction.
  - After release, the sequencer is in IDLE and waits for start.
- State codes:
  - idle=0, fetch1=1, fetch2=2, fetch3=3, clac=4.
  - ldac1..3=5..7, stac1..3=8..10, mvacr=11, mvrac=12, add=13, mul=14.
  - No other codes are ever driven.
- Opcode map:
  - 0x01 CLAC→4.
  - 0x02 LDAC→5,6,7.
  - 0x03 STAC→8,9,10.
  - 0x04 MVACR→11.
  - 0x05 MVRAC→12.
  - 0x06 ADD→13.
  - 0x07 MUL→14.
  - 0xFF END.
  - Everything else is illegal.
- Internal FSM: IDLE, FETCH1, FETCH2, FETCH3, DWAIT, EXEC, HALT. The state output is registered and changes only on clock edges.
  - IDLE: state=0, busy=0. start=1 at an edge → FETCH1.
  - FETCH1→FETCH2→FETCH3: one cycle each; state=1,2,3; busy=1.
  - DWAIT: state=0 for exactly DECODE_WAIT cycles; busy=1. The edge ending the last wait cycle samples opcode:
    - legal exec opcode → first state of its chain;
    - END → HALT;
    - illegal → illegal<=1, FETCH1, count unchanged.
  - EXEC: one cycle per chain state, in order. The edge leaving the last chain state → FETCH1, and instr_count increments by 1.
  - HALT: state=0, busy=0, halted=1. start is ignored; only reset exits.
- Counter: instr_count saturates at all-ones; no wrap.
- Opcode is sampled only at the decode edge; changes at other times have no effect.
- start is ignored outside IDLE. start held high continuously is legal; it only matters in IDLE.
- Latency:
  - start edge → fetch1 is visible after that edge.
  - Instruction length in cycles = 3 + DECODE_WAIT + chain length.
  - With the default: CLAC/MVACR/MVRAC/ADD/MUL = 6 cycles; LDAC/STAC = 8 cycles.

Test Plan:
- Reset then start=1 for one cycle, opcode=0x02 held → state sequence 1,2,3,0,0,5,6,7,1; instr_count=1 on the edge to the final 1; busy=1 throughout.
- Program stream CLAC, ADD, MUL, END (opcode changed only during fetch) → states 1,2,3,0,0,4, 1,2,3,0,0,13, 1,2,3,0,0,14, 1,2,3,0,0, then 0 forever. Also: halted=1, busy=0, instr_count=3, and start pulses afterwards cause no change.
- opcode=0x3C at decode → illegal=1, next state=1, instr_count unchanged; the following legal STAC gives 8,9,10 and count+1; illegal stays 1.
- Opcode toggled between 0x01 and 0x06 during fetch and the first wait cycle, then 0x06 at the decode edge → executes 13, not 4.
- reset_n driven low during ldac2 (state=6) → state=0, busy=0, counters cleared immediately without waiting for a clock edge; after release the sequencer stays idle until start.
- Counter preset scenario (CNT_W=2): 5 legal instructions → instr_count sequence 1,2,3,3,3 (saturates).

Source files
------------

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instruction_sequencer
// Purpose  : Produces the state code consumed by the processor control unit.
//            Walks fetch1..fetch3, idles while IR settles, decodes the opcode
//            from IR and steps through the matching execute chain before
//            returning to fetch1. Tracks retired instructions, END (halt) and
//            unknown opcodes (illegal).
// Ports    : clock       - system clock, rising edge
//            reset_n     - asynchronous active-low reset
//            start       - begin execution from idle (level)
//            opcode      - IR contents, sampled only at the decode edge
//            state       - registered state code to the control unit
//            busy        - running an instruction stream
//            halted      - END executed, sticky until reset
//            illegal     - unknown opcode seen, sticky until reset
//            instr_count - retired legal instructions (saturating, END excluded)
// Revision : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
  parameter int STATE_W     = 6,
  parameter int OPCODE_W    = 8,
  parameter int DECODE_WAIT = 2,
  parameter int CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [STATE_W-1:0]  state,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  // Internal sequencer states
  localparam logic [2:0] FSM_IDLE   = 3'd0;
  localparam logic [2:0] FSM_FETCH1 = 3'd1;
  localparam logic [2:0] FSM_FETCH2 = 3'd2;
  localparam logic [2:0] FSM_FETCH3 = 3'd3;
  localparam logic [2:0] FSM_DWAIT  = 3'd4;
  localparam logic [2:0] FSM_EXEC   = 3'd5;
  localparam logic [2:0] FSM_HALT   = 3'd6;

  // State codes driven to the control unit
  localparam logic [STATE_W-1:0] SC_IDLE   = STATE_W'(0);
  localparam logic [STATE_W-1:0] SC_FETCH1 = STATE_W'(1);
  localparam logic [STATE_W-1:0] SC_FETCH2 = STATE_W'(2);
  localparam logic [STATE_W-1:0] SC_FETCH3 = STATE_W'(3);
  localparam logic [STATE_W-1:0] SC_CLAC   = STATE_W'(4);
  localparam logic [STATE_W-1:0] SC_LDAC1  = STATE_W'(5);
  localparam logic [STATE_W-1:0] SC_LDAC2  = STATE_W'(6);
  localparam logic [STATE_W-1:0] SC_STAC1  = STATE_W'(8);
  localparam logic [STATE_W-1:0] SC_STAC2  = STATE_W'(9);
  localparam logic [STATE_W-1:0] SC_MVACR  = STATE_W'(11);
  localparam logic [STATE_W-1:0] SC_MVRAC  = STATE_W'(12);
  localparam logic [STATE_W-1:0] SC_ADD    = STATE_W'(13);
  localparam logic [STATE_W-1:0] SC_MUL    = STATE_W'(14);

  // Opcodes
  localparam logic [OPCODE_W-1:0] OP_CLAC  = OPCODE_W'(8'h01);
  localparam logic [OPCODE_W-1:0] OP_LDAC  = OPCODE_W'(8'h02);
  localparam logic [OPCODE_W-1:0] OP_STAC  = OPCODE_W'(8'h03);
  localparam logic [OPCODE_W-1:0] OP_MVACR = OPCODE_W'(8'h04);
  localparam logic [OPCODE_W-1:0] OP_MVRAC = OPCODE_W'(8'h05);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(8'h06);
  localparam logic [OPCODE_W-1:0] OP_MUL   = OPCODE_W'(8'h07);
  localparam logic [OPCODE_W-1:0] OP_END   = OPCODE_W'(8'hFF);

  // Wait counter counts down from DECODE_WAIT-1; decode happens when it is 0.
  localparam int                WAIT_W    = (DECODE_WAIT > 1) ? $clog2(DECODE_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(DECODE_WAIT - 1);

  logic [2:0]         fsm_q,     fsm_d;
  logic [STATE_W-1:0] state_q,   state_d;
  logic [WAIT_W-1:0]  wait_q,    wait_d;
  logic               halted_q,  halted_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q     <= FSM_IDLE;
      state_q   <= SC_IDLE;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. The state code is computed alongside the FSM transition
  // so the output is a plain flop and only changes on clock edges.
  // --------------------------------------------------------------------------
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    wait_d    = wait_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;

    case (fsm_q)
      FSM_IDLE: begin
        if (start) begin
          fsm_d   = FSM_FETCH1;
          state_d = SC_FETCH1;
        end
      end

      FSM_FETCH1: begin
        fsm_d   = FSM_FETCH2;
        state_d = SC_FETCH2;
      end

      FSM_FETCH2: begin
        fsm_d   = FSM_FETCH3;
        state_d = SC_FETCH3;
      end

      FSM_FETCH3: begin
        fsm_d   = FSM_DWAIT;
        state_d = SC_IDLE;
        wait_d  = WAIT_INIT;
      end

      FSM_DWAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          // Decode edge: the only point where opcode is looked at.
          fsm_d = FSM_EXEC;
          case (opcode)
            OP_CLAC:  state_d = SC_CLAC;
            OP_LDAC:  state_d = SC_LDAC1;
            OP_STAC:  state_d = SC_STAC1;
            OP_MVACR: state_d = SC_MVACR;
            OP_MVRAC: state_d = SC_MVRAC;
            OP_ADD:   state_d = SC_ADD;
            OP_MUL:   state_d = SC_MUL;
            OP_END: begin
              fsm_d    = FSM_HALT;
              state_d  = SC_IDLE;
              halted_d = 1'b1;
            end
            default: begin
              fsm_d     = FSM_FETCH1;
              state_d   = SC_FETCH1;
              illegal_d = 1'b1;
            end
          endcase
        end
      end

      FSM_EXEC: begin
        // Only LDAC and STAC have multi-state chains; their codes are
        // consecutive so the chain advances by incrementing the code.
        if (state_q == SC_LDAC1 || state_q == SC_LDAC2 ||
            state_q == SC_STAC1 || state_q == SC_STAC2) begin
          state_d = state_q + STATE_W'(1);
        end else begin
          fsm_d   = FSM_FETCH1;
          state_d = SC_FETCH1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      FSM_HALT: begin
        // Terminal until reset; start is ignored.
        state_d = SC_IDLE;
      end

      default: begin
        fsm_d   = FSM_IDLE;
        state_d = SC_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    case (fsm_q)
      FSM_FETCH1, FSM_FETCH2, FSM_FETCH3, FSM_DWAIT, FSM_EXEC: busy = 1'b1;
      default:                                                 busy = 1'b0;
    endcase
  end

  assign state       = state_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_sequencer
// Purpose  : Directed self-checking bench for instruction_sequencer. A second
//            instance with a 2-bit counter shares all stimulus and is used to
//            check counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [7:0]  opcode;
  logic [5:0]  state;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [15:0] instr_count;

  logic [5:0]  s_state;
  logic        s_busy;
  logic        s_halted;
  logic        s_illegal;
  logic [1:0]  s_count;

  int errors = 0;
  int checks = 0;

  instruction_sequencer #(
    .STATE_W(6), .OPCODE_W(8), .DECODE_WAIT(2), .CNT_W(16)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .state(state), .busy(busy), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  instruction_sequencer #(
    .STATE_W(6), .OPCODE_W(8), .DECODE_WAIT(2), .CNT_W(2)
  ) u_sat (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .state(s_state), .busy(s_busy), .halted(s_halted), .illegal(s_illegal),
    .instr_count(s_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step_expect(input string tag, input int exp_state);
    tick();
    check({tag, ".state"}, 32'(state), 32'(exp_state));
    check({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  // Pulse reset away from clock edges and leave the bench idle.
  task automatic do_reset();
    start   = 1'b0;
    opcode  = 8'h00;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start.state", 32'(state), 32'd1);
    check("start.busy", 32'(busy), 32'd1);
  endtask

  // Called while state=1 (fetch1). Drives op, expects fetch/wait, then the
  // chain first..first+len-1, then fetch1 again. len=0 means illegal opcode.
  task automatic do_instr(input logic [7:0] op, input int first, input int len);
    opcode = op;
    step_expect("f2", 2);
    step_expect("f3", 3);
    step_expect("w1", 0);
    step_expect("w2", 0);
    for (int k = 0; k < len; k++) step_expect("ex", first + k);
    step_expect("nf1", 1);
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    opcode  = 8'h00;
    #2;

    // Reset state
    reset_n = 1'b0;
    #2;
    check("rst.state", 32'(state), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.count", 32'(instr_count), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle.state", 32'(state), 32'd0);

    // LDAC with opcode held: 1,2,3,0,0,5,6,7,1
    opcode = 8'h02;
    start_pulse();
    for (int i = 0; i < 7; i++) begin
      int exp_s [7] = '{2, 3, 0, 0, 5, 6, 7};
      step_expect("ldac", exp_s[i]);
      check("ldac.count0", 32'(instr_count), 32'd0);
    end
    step_expect("ldac.end", 1);
    check("ldac.count1", 32'(instr_count), 32'd1);

    // Program CLAC, ADD, MUL, END
    do_reset();
    start_pulse();
    do_instr(8'h01, 4, 1);
    check("prog.count1", 32'(instr_count), 32'd1);
    do_instr(8'h06, 13, 1);
    do_instr(8'h07, 14, 1);
    check("prog.count3", 32'(instr_count), 32'd3);
    opcode = 8'hFF;
    step_expect("end.f2", 2);
    step_expect("end.f3", 3);
    step_expect("end.w1", 0);
    step_expect("end.w2", 0);
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      tick();
      check("halt.state", 32'(state), 32'd0);
      check("halt.busy", 32'(busy), 32'd0);
      check("halt.halted", 32'(halted), 32'd1);
      check("halt.count", 32'(instr_count), 32'd3);
    end
    start = 1'b0;

    // Illegal opcode then STAC
    do_reset();
    start_pulse();
    do_instr(8'h3C, 0, 0);
    check("ill.flag", 32'(illegal), 32'd1);
    check("ill.count", 32'(instr_count), 32'd0);
    do_instr(8'h03, 8, 3);
    check("stac.count", 32'(instr_count), 32'd1);
    check("stac.illegal", 32'(illegal), 32'd1);

    // Opcode toggling before the decode edge has no effect
    do_reset();
    start_pulse();
    opcode = 8'h01;
    step_expect("tog.f2", 2);
    opcode = 8'h06;
    step_expect("tog.f3", 3);
    opcode = 8'h01;
    step_expect("tog.w1", 0);
    opcode = 8'h01;
    step_expect("tog.w2", 0);
    opcode = 8'h06;
    step_expect("tog.ex", 13);
    step_expect("tog.nf1", 1);

    // Async reset during ldac2 clears everything without a clock edge
    do_reset();
    start_pulse();
    do_instr(8'h3C, 0, 0);
    do_instr(8'h02, 5, 3);
    check("pre.count", 32'(instr_count), 32'd1);
    step_expect("mid.f2", 2);
    step_expect("mid.f3", 3);
    step_expect("mid.w1", 0);
    step_expect("mid.w2", 0);
    step_expect("mid.l1", 5);
    step_expect("mid.l2", 6);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.state", 32'(state), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.count", 32'(instr_count), 32'd0);
    check("arst.illegal", 32'(illegal), 32'd0);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post.state", 32'(state), 32'd0);
      check("post.busy", 32'(busy), 32'd0);
    end

    // Counter saturation on the 2-bit instance
    do_reset();
    start_pulse();
    for (int i = 0; i < 5; i++) begin
      int exp_sat [5] = '{1, 2, 3, 3, 3};
      do_instr(8'h01, 4, 1);
      check("sat.count", 32'(s_count), 32'(exp_sat[i]));
      check("wide.count", 32'(instr_count), 32'(i + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
